// File: rtl/tile_fragment_walker.sv
// tile_fragment_walker: walks a TILE_DIM x TILE_DIM tile in raster order and emits covered fragments.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vld_in / rdy_in   setup bundle handshake (rdy_in high only while idle)
//   in_abs_pos        tile origin 12.4 (z unused)
//   in_delta_0/1/2    edge deltas v(i+1)-v(i), 12.4
//   in_edge_0/1/2     edge values at the origin, 8 fractional bits
//   in_metadata       color plus tile indices (indices unused here)
//   in_dzdx, in_dzdy  depth gradients, 12.4
//   in_z_current      depth at the origin, 8 fractional bits
//   vld_out / rdy_out fragment handshake
//   out_pos, out_color fragment position (12.4), depth (12.4) and color
//   tile_done         one-cycle pulse after the last pixel of a tile is walked
// Optional feature: define RASTER_TOP_LEFT_EN for the top-left fill rule on zero edges.

`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif
`ifndef FX_FRAC_BITS
`define FX_FRAC_BITS 4
`endif
`ifndef TILE_WIDTH_BITS
`define TILE_WIDTH_BITS 4
`endif
`ifndef COLOR_BITS
`define COLOR_BITS 24
`endif

package tile_fragment_walker_pkg;
    typedef struct packed {
        logic signed [`FX_TOTAL_BITS-1:0] x;
        logic signed [`FX_TOTAL_BITS-1:0] y;
        logic signed [`FX_TOTAL_BITS-1:0] z;
    } coord_3d_t;
    typedef struct packed {
        logic [`COLOR_BITS-1:0] color;
        logic [7:0]             tile_x;
        logic [7:0]             tile_y;
    } metadata_t;
endpackage

module tile_fragment_walker
    import tile_fragment_walker_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              vld_in,
    output logic                              rdy_in,
    input  coord_3d_t                         in_abs_pos,
    input  coord_3d_t                         in_delta_0,
    input  coord_3d_t                         in_delta_1,
    input  coord_3d_t                         in_delta_2,
    input  logic signed [2*`FX_TOTAL_BITS-1:0] in_edge_0,
    input  logic signed [2*`FX_TOTAL_BITS-1:0] in_edge_1,
    input  logic signed [2*`FX_TOTAL_BITS-1:0] in_edge_2,
    input  metadata_t                         in_metadata,
    input  logic signed [`FX_TOTAL_BITS-1:0]   in_dzdx,
    input  logic signed [`FX_TOTAL_BITS-1:0]   in_dzdy,
    input  logic signed [2*`FX_TOTAL_BITS-1:0] in_z_current,
    input  logic                              rdy_out,
    output logic                              vld_out,
    output coord_3d_t                         out_pos,
    output logic [`COLOR_BITS-1:0]            out_color,
    output logic                              tile_done
);
    localparam int W = `FX_TOTAL_BITS;
    localparam int W2 = 2 * W;
    localparam int F = `FX_FRAC_BITS;
    localparam int TB = `TILE_WIDTH_BITS;
    localparam int TILE_DIM = 1 << TB;
    localparam int C = `COLOR_BITS;

    typedef enum logic {IDLE, WALK} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        abs_x_q, abs_x_d, abs_y_q, abs_y_d;
    logic [2:0][W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [W-1:0]        dzdx_q, dzdx_d, dzdy_q, dzdy_d;
    logic [C-1:0]        color_q, color_d;
    logic [2:0][W2-1:0]  e_q, e_d, row_e_q, row_e_d;
    logic [W2-1:0]       z_acc_q, z_acc_d, row_z_q, row_z_d;
    logic [TB-1:0]       col_q, col_d, row_q, row_d;
    logic                vld_out_q, vld_out_d;
    coord_3d_t           out_pos_q, out_pos_d;
    logic [C-1:0]        out_color_q, out_color_d;
    logic                tile_done_q, tile_done_d;
    logic [2:0][W-1:0]   in_dx, in_dy;
    logic [2:0][W2-1:0]  in_e;
    logic [2:0]          hit;
    logic                adv;
    logic                unused_ok;

    assign in_dx = {in_delta_2.x, in_delta_1.x, in_delta_0.x};
    assign in_dy = {in_delta_2.y, in_delta_1.y, in_delta_0.y};
    assign in_e = {in_edge_2, in_edge_1, in_edge_0};
    assign unused_ok = ^{in_abs_pos.z, in_delta_0.z, in_delta_1.z, in_delta_2.z,
                         in_metadata.tile_x, in_metadata.tile_y};

    assign rdy_in = state_q == IDLE;
    assign vld_out = vld_out_q;
    assign out_pos = out_pos_q;
    assign out_color = out_color_q;
    assign tile_done = tile_done_q;

    // The walker only steps when the single output register can take a new fragment.
    assign adv = state_q == WALK && (!vld_out_q || rdy_out);

    // Sign-extend a 12.4 step to the accumulator width and align it to 8 fractional bits.
    function automatic logic [W2-1:0] sx(input logic [W-1:0] v);
        return {{(W2-W){v[W-1]}}, v} << F;
    endfunction

    always_comb begin
        hit = '0;
        for (int i = 0; i < 3; i++) begin
`ifdef RASTER_TOP_LEFT_EN
            hit[i] = $signed(e_q[i]) > 0 ||
                     (e_q[i] == '0 && ($signed(dy_q[i]) < 0 || (dy_q[i] == '0 && $signed(dx_q[i]) > 0)));
`else
            hit[i] = !e_q[i][W2-1];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        abs_x_d = abs_x_q;
        abs_y_d = abs_y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        dzdx_d = dzdx_q;
        dzdy_d = dzdy_q;
        color_d = color_q;
        e_d = e_q;
        row_e_d = row_e_q;
        z_acc_d = z_acc_q;
        row_z_d = row_z_q;
        col_d = col_q;
        row_d = row_q;
        vld_out_d = vld_out_q && !rdy_out;
        out_pos_d = out_pos_q;
        out_color_d = out_color_q;
        tile_done_d = 1'b0;
        if (state_q == IDLE) begin
            if (vld_in) begin
                abs_x_d = in_abs_pos.x;
                abs_y_d = in_abs_pos.y;
                dx_d = in_dx;
                dy_d = in_dy;
                dzdx_d = in_dzdx;
                dzdy_d = in_dzdy;
                color_d = in_metadata.color;
                e_d = in_e;
                row_e_d = in_e;
                z_acc_d = in_z_current;
                row_z_d = in_z_current;
                col_d = '0;
                row_d = '0;
                state_d = WALK;
            end
        end else if (adv) begin
            if (&hit) begin
                vld_out_d = 1'b1;
                out_pos_d.x = abs_x_q + (W'(col_q) << F);
                out_pos_d.y = abs_y_q + (W'(row_q) << F);
                out_pos_d.z = z_acc_q[W+F-1:F];
                out_color_d = color_q;
            end
            if (col_q == TB'(TILE_DIM - 1)) begin
                for (int i = 0; i < 3; i++) begin
                    row_e_d[i] = row_e_q[i] - sx(dx_q[i]);
                    e_d[i] = row_e_d[i];
                end
                row_z_d = row_z_q + sx(dzdy_q);
                z_acc_d = row_z_d;
                col_d = '0;
                row_d = row_q + 1'b1;
                if (row_q == TB'(TILE_DIM - 1)) begin
                    tile_done_d = 1'b1;
                    state_d = IDLE;
                end
            end else begin
                for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + sx(dy_q[i]);
                z_acc_d = z_acc_q + sx(dzdx_q);
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            abs_x_q <= '0;
            abs_y_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            dzdx_q <= '0;
            dzdy_q <= '0;
            color_q <= '0;
            e_q <= '0;
            row_e_q <= '0;
            z_acc_q <= '0;
            row_z_q <= '0;
            col_q <= '0;
            row_q <= '0;
            vld_out_q <= 1'b0;
            out_pos_q <= '0;
            out_color_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abs_x_q <= abs_x_d;
            abs_y_q <= abs_y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            dzdx_q <= dzdx_d;
            dzdy_q <= dzdy_d;
            color_q <= color_d;
            e_q <= e_d;
            row_e_q <= row_e_d;
            z_acc_q <= z_acc_d;
            row_z_q <= row_z_d;
            col_q <= col_d;
            row_q <= row_d;
            vld_out_q <= vld_out_d;
            out_pos_q <= out_pos_d;
            out_color_q <= out_color_d;
            tile_done_q <= tile_done_d;
        end
    end
endmodule
